// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants and fetch FSM encoding.
package fetch_stage_pkg;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] NOP = NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc1_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc1_o,
    output logic        valid_o
);

    logic [15:0] instr_q;
    logic [15:0] pc1_q;
    logic        valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bubble_i) begin
            instr_q <= NOP;
            pc1_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc1_q   <= pc1_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc1_o   = pc1_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, skid buffer and redirect squash.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P  = RESET_PC,
    parameter logic [15:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic        IF_clk,
    input  logic        IF_rst_n,
    input  logic        IF_stall,
    input  logic        IF_redirect,
    input  logic [15:0] IF_redirect_pc,
    output logic        IF_imem_req,
    output logic [15:0] IF_imem_addr,
    input  logic        IF_imem_ready,
    input  logic [15:0] IF_imem_rdata,
    output logic [15:0] IF_instruction,
    output logic [15:0] IF_pc_plus1,
    output logic        IF_valid
);

    fetch_state_e state_q, state_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  pending_q, pending_d;
    logic [15:0]  skid_instr_q, skid_instr_d;
    logic [15:0]  skid_pc1_q, skid_pc1_d;
    logic         ld, bub;
    logic [15:0]  ld_instr, ld_pc1;
    logic [15:0]  pc_inc;

    assign pc_inc = fetch_pc_q + 16'h0001;

    always_ff @(posedge IF_clk) begin
        if (!IF_rst_n) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC_P;
            pending_q    <= 16'h0000;
            skid_instr_q <= 16'h0000;
            skid_pc1_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            skid_instr_q <= skid_instr_d;
            skid_pc1_q   <= skid_pc1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        skid_instr_d = skid_instr_q;
        skid_pc1_d   = skid_pc1_q;
        ld           = 1'b0;
        bub          = 1'b0;
        ld_instr     = IF_imem_rdata;
        ld_pc1       = pc_inc;
        if (IF_redirect) begin
            bub          = 1'b1;
            skid_instr_d = 16'h0000;
            skid_pc1_d   = 16'h0000;
            // An unanswered request must stay on the bus until it drains.
            if (state_q != HOLD && !IF_imem_ready) begin
                pending_d = IF_redirect_pc;
                state_d   = KILL;
            end else begin
                fetch_pc_d = IF_redirect_pc;
                state_d    = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (IF_imem_ready) begin
                        fetch_pc_d = pc_inc;
                        if (IF_stall) begin
                            skid_instr_d = IF_imem_rdata;
                            skid_pc1_d   = pc_inc;
                            state_d      = HOLD;
                        end else begin
                            ld = 1'b1;
                        end
                    end else if (!IF_stall) begin
                        bub = 1'b1;
                    end
                end
                HOLD: begin
                    if (!IF_stall) begin
                        ld       = 1'b1;
                        ld_instr = skid_instr_q;
                        ld_pc1   = skid_pc1_q;
                        state_d  = FETCH;
                    end
                end
                KILL: begin
                    bub = 1'b1;
                    if (IF_imem_ready) begin
                        fetch_pc_d = pending_q;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign IF_imem_req  = (state_q != HOLD);
    assign IF_imem_addr = fetch_pc_q;

    if_id_reg #(
        .NOP(NOP_INSTR_P)
    ) u_if_id (
        .clk_i   (IF_clk),
        .rst_ni  (IF_rst_n),
        .load_i  (ld),
        .bubble_i(bub),
        .instr_i (ld_instr),
        .pc1_i   (ld_pc1),
        .instr_o (IF_instruction),
        .pc1_o   (IF_pc_plus1),
        .valid_o (IF_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Vector table plus scoreboard queue for fetch_stage.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, redir, ready;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr, rdata, instr, pc1;
    logic        valid;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        ready;
        logic        ereq;
        logic [15:0] eaddr;
        logic [15:0] einstr;
        logic [15:0] epc1;
        logic        evalid;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory answers with 0x1000 + address.
    assign rdata = 16'h1000 + addr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .IF_clk        (clk),
        .IF_rst_n      (rst_n),
        .IF_stall      (stall),
        .IF_redirect   (redir),
        .IF_redirect_pc(rpc),
        .IF_imem_req   (req),
        .IF_imem_addr  (addr),
        .IF_imem_ready (ready),
        .IF_imem_rdata (rdata),
        .IF_instruction(instr),
        .IF_pc_plus1   (pc1),
        .IF_valid      (valid)
    );

    task automatic add(input logic r, input logic s, input logic d,
                       input logic [15:0] p, input logic rd,
                       input logic eq, input logic [15:0] ea,
                       input logic [15:0] ei, input logic [15:0] ep,
                       input logic ev);
        vec_t t;
        t.rst_n = r; t.stall = s; t.redir = d; t.rpc = p; t.ready = rd;
        t.ereq = eq; t.eaddr = ea; t.einstr = ei; t.epc1 = ep;
        t.evalid = ev;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp, input int idx);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h want %h", idx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk);
        rst_n = t.rst_n; stall = t.stall; redir = t.redir;
        rpc = t.rpc; ready = t.ready;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("req", {15'd0, req}, {15'd0, e.ereq}, idx);
        chk("addr", addr, e.eaddr, idx);
        chk("instr", instr, e.einstr, idx);
        chk("valid", {15'd0, valid}, {15'd0, e.evalid}, idx);
        if (e.evalid || !e.rst_n)
            chk("pc1", pc1, e.epc1, idx);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0;
        rpc = 16'h0; ready = 1'b0;
        // rst stl red rpc rdy | req addr instr pc1 valid
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, NOP_INSTR, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0000, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h1000, 16'h0001, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h1001, 16'h0002, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0003, 16'h1002, 16'h0003, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h1003, 16'h0004, 1);
        add(1, 1, 0, 16'h0000, 1, 0, 16'h0005, 16'h1003, 16'h0004, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 16'h0005, 16'h1003, 16'h0004, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 16'h0005, 16'h1003, 16'h0004, 1);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0005, 16'h1004, 16'h0005, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h1005, 16'h0006, 1);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0006, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 1, 16'h0005, 1, 1, 16'h0005, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 1, 16'h0040, 0, 1, 16'h0005, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 0, 1, 16'h0005, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0040, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0041, 16'h1040, 16'h0041, 1);
        add(1, 1, 0, 16'h0000, 1, 0, 16'h0042, 16'h1040, 16'h0041, 1);
        add(1, 1, 1, 16'h0080, 0, 1, 16'h0080, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0081, 16'h1080, 16'h0081, 1);
        add(1, 1, 1, 16'hFFFE, 0, 1, 16'h0081, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'hFFFE, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'hFFFF, 16'h0FFE, 16'hFFFF, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0FFF, 16'h0000, 1);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h1000, 16'h0001, 1);
        add(1, 0, 1, 16'h0200, 0, 1, 16'h0001, NOP_INSTR, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 0, 1, 16'h0000, NOP_INSTR, 16'h0000, 0);
        add(1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h1000, 16'h0001, 1);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Slow memory: address held, decode drains to bubbles.
        for (int i = 0; i < 4; i++) begin
            vec_t t;
            t.rst_n = 1; t.stall = 0; t.redir = 0; t.rpc = 16'h0;
            t.ready = 0; t.ereq = 1; t.eaddr = 16'h0001;
            t.einstr = NOP_INSTR; t.epc1 = 16'h0; t.evalid = 0;
            apply(t, 100 + i);
        end
        // Stalled while waiting: IF/ID keeps the bubble, then data lands.
        begin
            vec_t t;
            t.rst_n = 1; t.stall = 1; t.redir = 0; t.rpc = 16'h0;
            t.ready = 0; t.ereq = 1; t.eaddr = 16'h0001;
            t.einstr = NOP_INSTR; t.epc1 = 16'h0; t.evalid = 0;
            apply(t, 200);
            t.stall = 0; t.ready = 1; t.eaddr = 16'h0002;
            t.einstr = 16'h1001; t.epc1 = 16'h0002; t.evalid = 1;
            apply(t, 201);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
